// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready handshake, flush and sticky halt tracking.
// Optional stall/bubble performance counters are built when PIPE_PERF_EN is defined.
module pipe_stage_buf #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_halt,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_halt,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         halted
`ifdef PIPE_PERF_EN
   ,
   output logic [CNT_W-1:0]             stall_cnt,
   output logic [CNT_W-1:0]             bubble_cnt
`endif
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   if ((WIDTH < 1) || (DEPTH < 1) || (CNT_W < 1)) begin : g_bad_param
      $error("pipe_stage_buf: WIDTH, DEPTH and CNT_W must all be >= 1");
   end

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             halt_mem_r [DEPTH];
   logic [PW-1:0]    rd_ptr_r;
   logic [PW-1:0]    wr_ptr_r;
   logic [CW-1:0]    count_r;
   logic             halt_pend_r;
   logic             halted_r;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             head_halt_s;
   logic             enq_s;
   logic             deq_s;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      if (p == LAST_PTR) begin
         return {PW{1'b0}};
      end else begin
         return p + {{(PW-1){1'b0}}, 1'b1};
      end
   endfunction

   // Handshake qualification; a full buffer still accepts when the head leaves this cycle.
   always_comb begin
      out_valid_s = (count_r != {CW{1'b0}});
      head_halt_s = halt_mem_r[rd_ptr_r];
      in_ready_s  = ~halt_pend_r & ~flush & ((count_r < DEPTH_C) | out_ready);
      enq_s       = in_valid & in_ready_s;
      deq_s       = out_valid_s & out_ready;
   end

   // Head presentation, masked to zero when the buffer is empty.
   always_comb begin
      if (out_valid_s) begin
         out_data = mem_r[rd_ptr_r];
         out_halt = head_halt_s;
      end else begin
         out_data = {WIDTH{1'b0}};
         out_halt = 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_s;
   assign count     = count_r;
   assign halted    = halted_r;

   // Payload storage; not reset, the output mask hides stale contents.
   always_ff @(posedge CLK) begin
      if (enq_s && !RST) begin
         mem_r[wr_ptr_r]      <= in_data;
         halt_mem_r[wr_ptr_r] <= in_halt;
      end
   end

   // Occupancy, pointers and halt tracking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rd_ptr_r    <= {PW{1'b0}};
         wr_ptr_r    <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         halt_pend_r <= 1'b0;
         halted_r    <= 1'b0;
      end else if (flush) begin
         // The consumer still takes the head on a flush edge, so a HALT head counts.
         rd_ptr_r    <= {PW{1'b0}};
         wr_ptr_r    <= {PW{1'b0}};
         count_r     <= {CW{1'b0}};
         halt_pend_r <= 1'b0;
         halted_r    <= halted_r | (deq_s & head_halt_s);
      end else begin
         if (enq_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (deq_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
         halt_pend_r <= halt_pend_r | (enq_s & in_halt);
         halted_r    <= halted_r | (deq_s & head_halt_s);
      end
   end

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] bubble_cnt_r;

   // Saturating stall and bubble counters, cleared only by reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cnt_r  <= {CNT_W{1'b0}};
         bubble_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (in_valid && !in_ready_s && !(&stall_cnt_r)) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (!out_valid_s && out_ready && !(&bubble_cnt_r)) begin
            bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign stall_cnt  = stall_cnt_r;
   assign bubble_cnt = bubble_cnt_r;
`endif

endmodule
